// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: memory-mapped 8N1 UART transmitter behind the decoder's UART window.
// Offsets: 0x0 TXDATA, 0x4 STATUS, 0x8 CTRL. A one-deep holding buffer feeds a shift register.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit to every frame and
// sets STATUS bit3 as a capability flag.
module uart_mmio_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WrtEn,
  input  logic [ADDR_WIDTH-1:0] ADDRIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_CAP = 1'b1;
`else
  localparam logic PARITY_CAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state;
  logic [7:0]          hold_buf;
  logic                hold_full;
  logic                overrun;
  logic [7:0]          last_byte;
  logic [7:0]          shifter;
  logic [2:0]          bit_cnt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic                tx_r;
`ifdef UART_TX_PARITY_EN
  logic                parity_bit;
`endif

  logic [ADDR_WIDTH-3:0] word_addr;
  logic sel_txdata, sel_status, sel_ctrl;
  logic baud_last, pull, wr_tx, accept, set_overrun, clr_overrun;
  logic unused_bits;

  // Word-aligned decode; the byte-lane bits and the upper store-data bits carry no meaning here.
  assign word_addr   = ADDRIn[ADDR_WIDTH-1:2];
  assign sel_txdata  = (word_addr == '0);
  assign sel_status  = (word_addr == (ADDR_WIDTH-2)'(1));
  assign sel_ctrl    = (word_addr == (ADDR_WIDTH-2)'(2));
  assign unused_bits = ^{ADDRIn[1:0], DataIn[DATA_WIDTH-1:8]};

  // The FSM pulls the held byte either from IDLE or on the final clock of STOP,
  // which makes a simultaneous TXDATA write an accept rather than an overrun.
  assign baud_last   = (baud_cnt == BAUD_LAST);
  assign pull        = hold_full && ((state == IDLE) || ((state == STOP) && baud_last));
  assign wr_tx       = WrtEn && sel_txdata;
  assign accept      = wr_tx && (!hold_full || pull);
  assign set_overrun = wr_tx && hold_full && !pull;
  assign clr_overrun = WrtEn && sel_ctrl && DataIn[0];

  assign tx      = tx_r;
  assign tx_busy = (state != IDLE) || hold_full;

  // Holding buffer, last-accepted byte and sticky overrun flag (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_buf  <= 8'h00;
      hold_full <= 1'b0;
      last_byte <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        hold_buf  <= DataIn[7:0];
        last_byte <= DataIn[7:0];
        hold_full <= 1'b1;
      end else if (pull) begin
        hold_full <= 1'b0;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  // Frame sequencer with a registered serial output; baud counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shifter  <= 8'h00;
      bit_cnt  <= 3'd0;
      baud_cnt <= '0;
      tx_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_r     <= 1'b1;
          baud_cnt <= '0;
          if (hold_full) begin
            shifter <= hold_buf;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^hold_buf;
`endif
            state   <= START;
            tx_r    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            state    <= DATA;
            tx_r     <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx_r  <= parity_bit;
`else
              state <= STOP;
              tx_r  <= 1'b1;
`endif
            end else begin
              shifter <= {1'b0, shifter[7:1]};
              tx_r    <= shifter[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_r     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (hold_full) begin
              shifter <= hold_buf;
`ifdef UART_TX_PARITY_EN
              parity_bit <= ^hold_buf;
`endif
              state   <= START;
              tx_r    <= 1'b0;
            end else begin
              state <= IDLE;
              tx_r  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx_r     <= 1'b1;
        end
      endcase
    end
  end

  // Side-effect-free register read mux for the CPU load path.
  always_comb begin
    DataOut = '0;
    if (sel_txdata) begin
      DataOut[7:0] = last_byte;
    end else if (sel_status) begin
      DataOut[3:0] = {PARITY_CAP, overrun, hold_full, (state != IDLE)};
    end
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb_uart_mmio_tx: directed self-checking bench for uart_mmio_tx with CLKS_PER_BIT=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_uart_mmio_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [31:0] CAP = 32'h8;
`else
  localparam int NBITS = 10;
  localparam logic [31:0] CAP = 32'h0;
`endif

  logic        clk;
  logic        reset;
  logic        WrtEn;
  logic [31:0] ADDRIn;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        tx;
  logic        tx_busy;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] rd;

  uart_mmio_tx #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .WrtEn  (WrtEn),
    .ADDRIn (ADDRIn),
    .DataIn (DataIn),
    .DataOut(DataOut),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  // Free-running 100 MHz bench clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    WrtEn  = we;
    ADDRIn = addr;
    DataIn = data;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] v);
    WrtEn  = 1'b0;
    ADDRIn = addr;
    #1;
    v = DataOut;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected line level for frame slot idx: start, 8 data bits LSB first, optional parity, stop.
  function automatic logic expBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && NBITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Check every clock of one frame; optionally issue TXDATA writes during its first two clocks.
  task automatic checkFrame(input logic [7:0] b, input string tag, input int nw,
                            input logic [7:0] w0, input logic [7:0] w1, input logic [31:0] mid_status);
    logic [31:0] v;
    for (int k = 0; k < NBITS*CPB; k++) begin
      if (k == 0 && nw >= 1)      applyStimulus(1'b1, 32'h0, {24'h0, w0});
      else if (k == 1 && nw >= 2) applyStimulus(1'b1, 32'h0, {24'h0, w1});
      else                        applyStimulus(1'b0, 32'h0, 32'h0);
      cycle();
      checkOutput($sformatf("%s_tx_k%0d", tag, k), {31'b0, tx}, {31'b0, expBit(b, k/CPB)});
      if (k == 20) begin
        readReg(32'h4, v);
        checkOutput({tag, "_status_mid"}, v, mid_status);
      end
      if (k == NBITS*CPB-1) checkOutput({tag, "_busy_last"}, {31'b0, tx_busy}, 32'h1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
  endtask

  // Run n idle clocks and require the line to stay high the whole time.
  task automatic checkIdle(input string tag, input int n);
    int lows = 0;
    int busys = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    checkOutput({tag, "_low_clocks"}, lows, 0);
    checkOutput({tag, "_busy_clocks"}, busys, 0);
  endtask

  // Directed sequence: reset, single frame, back-to-back, overrun, mid-frame reset, gating.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    checkOutput("rst_tx", {31'b0, tx}, 32'h1);
    checkOutput("rst_busy", {31'b0, tx_busy}, 32'h0);
    readReg(32'h4, rd); checkOutput("rst_status", rd, CAP);
    readReg(32'h0, rd); checkOutput("rst_txdata", rd, 32'h0);
    readReg(32'h8, rd); checkOutput("rst_ctrl", rd, 32'h0);

    $display("[TB] single byte 0xA5");
    applyStimulus(1'b1, 32'h0, 32'hFFFF_FFA5);
    cycle();
    checkOutput("single_tx_at_write", {31'b0, tx}, 32'h1);
    checkOutput("single_busy_at_write", {31'b0, tx_busy}, 32'h1);
    checkFrame(8'hA5, "single", 0, 8'h0, 8'h0, 32'h1 | CAP);
    cycle();
    checkOutput("single_busy_end", {31'b0, tx_busy}, 32'h0);
    checkOutput("single_tx_end", {31'b0, tx}, 32'h1);
    readReg(32'h0, rd); checkOutput("single_txdata", rd, 32'h0000_00A5);

    $display("[TB] back-to-back 0x55 then 0x0F");
    applyStimulus(1'b1, 32'h0, 32'h55);
    cycle();
    checkFrame(8'h55, "b2b1", 1, 8'h0F, 8'h0, 32'h3 | CAP);
    checkFrame(8'h0F, "b2b2", 0, 8'h0, 8'h0, 32'h1 | CAP);
    cycle();
    checkOutput("b2b_busy_end", {31'b0, tx_busy}, 32'h0);
    readReg(32'h0, rd); checkOutput("b2b_txdata", rd, 32'h0F);

    $display("[TB] overrun 0x11, 0x22, 0x33");
    applyStimulus(1'b1, 32'h0, 32'h11);
    cycle();
    checkFrame(8'h11, "ovr1", 2, 8'h22, 8'h33, 32'h7 | CAP);
    checkFrame(8'h22, "ovr2", 0, 8'h0, 8'h0, 32'h5 | CAP);
    cycle();
    readReg(32'h4, rd); checkOutput("ovr_status_idle", rd, 32'h4 | CAP);
    readReg(32'h0, rd); checkOutput("ovr_txdata", rd, 32'h22);
    applyStimulus(1'b1, 32'h8, 32'h1);
    cycle();
    readReg(32'h4, rd); checkOutput("ovr_status_cleared", rd, CAP);
    checkIdle("ovr_no_0x33", 20);

    $display("[TB] reset during data bit 3 of 0xFF");
    applyStimulus(1'b1, 32'h0, 32'hFF);
    cycle();
    applyStimulus(1'b1, 32'h0, 32'h00);
    cycle();
    applyStimulus(1'b0, 32'h0, 32'h0);
    repeat (16) cycle();
    readReg(32'h4, rd); checkOutput("rstmid_status_before", rd, 32'h3 | CAP);
    reset = 1'b1;
    cycle();
    checkOutput("rstmid_tx", {31'b0, tx}, 32'h1);
    checkOutput("rstmid_busy", {31'b0, tx_busy}, 32'h0);
    readReg(32'h4, rd); checkOutput("rstmid_status", rd, CAP);
    readReg(32'h0, rd); checkOutput("rstmid_txdata", rd, 32'h0);
    reset = 1'b0;
    checkIdle("rstmid_no_frame", 50);

    $display("[TB] decoder gating and unmapped offsets");
    applyStimulus(1'b0, 32'h0, 32'h99);
    cycle();
    applyStimulus(1'b1, 32'hC, 32'h77);
    #1;
    checkOutput("unmapped_read_0xC", DataOut, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'h4, 32'h66);
    cycle();
    applyStimulus(1'b0, 32'h0, 32'h0);
    readReg(32'h0, rd); checkOutput("gate_txdata", rd, 32'h0);
    readReg(32'h4, rd); checkOutput("gate_status", rd, CAP);
    readReg(32'h10, rd); checkOutput("unmapped_read_0x10", rd, 32'h0);
    checkIdle("gate_no_frame", 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_mmio_tx.md
Name: uart_mmio_tx

Overview:
- Memory-mapped UART transmit peripheral that sits behind the address decoder's UART window (base 0x1001002C).
- Receives the decoder's write strobe and the offset address already rebased to zero.
- Returns read data combinationally for the single-cycle CPU's load mux.
- Serialises bytes 8N1 (LSB first) on a one-deep holding buffer plus a shift register.

Parameters:
- DATA_WIDTH, 32, width of the CPU data bus.
- ADDR_WIDTH, 32, width of the rebased offset address.
- CLKS_PER_BIT, 5208, clocks per serial bit (50 MHz / 9600 baud); must be ≥2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- WrtEn  input  1  decoder UART write strobe (already qualified by CPU store)
- ADDRIn  input  ADDR_WIDTH  rebased offset within the UART window
- DataIn  input  DATA_WIDTH  CPU store data
- DataOut  output  DATA_WIDTH  combinational register read data
- tx  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is on the line or the holding buffer is full

Behaviour:
- Register map (offset, word aligned; ADDRIn[1:0] ignored):
  - 0x0 TXDATA: write DataIn[7:0] to the holding buffer; read returns {24'b0, last accepted byte}.
  - 0x4 STATUS: read-only; bit0 = shifter active, bit1 = hold_full, bit2 = overrun, other bits 0.
  - 0x8 CTRL: write with DataIn[0]=1 clears overrun; read returns 0.
  - Other offsets: writes ignored, read 0.
- DataOut is purely combinational from ADDRIn and state; no read side effects.
- Reset values:
  - tx=1, tx_busy=0, FSM=IDLE, hold_full=0, overrun=0.
  - Last-byte register=0, bit counter=0, baud counter=0.
- Holding buffer:
  - A TXDATA write while hold_full=0 loads the byte and sets hold_full at the next edge.
  - A TXDATA write while hold_full=1 is dropped and sets overrun (sticky).
  - If the FSM pulls the held byte on the same edge as a TXDATA write, the write is accepted: hold_full stays 1 with the new byte, and no overrun.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If hold_full, move the byte to the shifter, clear hold_full, go to START. A byte written at edge N therefore drives tx=0 after edge N+1.
  - START: tx=0 for CLKS_PER_BIT clocks, then DATA.
  - DATA: tx=shifter[0] for CLKS_PER_BIT clocks per bit. Shift right each bit. After 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT clocks. On the last clock, if hold_full, load the shifter and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state change.
- Frame length: exactly 10·CLKS_PER_BIT clocks.
- tx_busy = (FSM≠IDLE) | hold_full, registered-consistent (derived from registered state, glitch-free).
- Reset asserted mid-frame: frame aborted, tx=1 after that edge, buffered byte discarded, overrun cleared.
- CTRL clear and an overrun-setting write in the same cycle: set wins (overrun stays 1).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT clocks.
  - Frame becomes 11·CLKS_PER_BIT clocks.
  - STATUS bit3 reads 1 (parity capability flag).
- Undefined: no PARITY state, 8N1 framing, STATUS bit3 reads 0.

Test Plan:
- Reset then idle (CLKS_PER_BIT=4): after reset, tx=1, tx_busy=0, STATUS read=0x0, TXDATA read=0x0.
- Single byte: write 0xA5 to offset 0x0.
  - tx=0 for 4 clocks starting one clock after the write.
  - Then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then 1 for 4 clocks.
  - tx_busy drops after 40 clocks of frame.
  - TXDATA reads 0x000000A5.
- Back-to-back: write 0x55, then 0x0F during the first frame.
  - Second start bit begins immediately after the first stop bit with no idle clock.
  - STATUS bit1 reads 1 until the second frame starts.
- Overrun: write 0x11, 0x22 (hold full), 0x33 while 0x22 is still held.
  - 0x33 is never transmitted; STATUS reads 0x7 during the frame.
  - CTRL write 0x1 then STATUS bit2=0.
- Reset mid-frame: assert reset during DATA bit 3 of 0xFF; tx=1 on the next clock, STATUS=0, no further frame.
- Unmapped/decoder gating: write with WrtEn=0 to 0x0 and write with WrtEn=1 to 0xC → no frame, no state change, DataOut=0 for 0xC.
